// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST inference sequencer.
// Holds the FSM state encoding, default sizes and a saturating increment.
package mnist_pkg;

    localparam int NPIX_DEF    = 784;
    localparam int NCLS_DEF    = 10;
    localparam int ACC_W_DEF   = 32;
    localparam int MAC_LAT_DEF = 2;
    localparam int CLS_W       = $clog2(NCLS_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_ARGMAX,
        S_DONE
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mnist_argmax.sv
// Serial signed argmax: one candidate per valid cycle, strict compare.
// The best_* outputs already include the value presented this cycle.
module mnist_argmax
    import mnist_pkg::*;
#(
    parameter int NCLS  = NCLS_DEF,
    parameter int ACC_W = ACC_W_DEF,
    localparam int CW   = $clog2(NCLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [ACC_W-1:0] val_i,
    output logic [CW-1:0]    best_idx_o,
    output logic [ACC_W-1:0] best_val_o
);

    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    cur_idx;
    logic [CW-1:0]    best_idx_q;
    logic [ACC_W-1:0] best_val_q;
    logic             take;

    // Candidate selection; ties keep the earlier (lower) index
    always_comb begin
        cur_idx    = start_i ? '0 : idx_q;
        take       = start_i ||
                     ($signed(val_i) > $signed(best_val_q));
        best_idx_o = best_idx_q;
        best_val_o = best_val_q;
        if (valid_i && take) begin
            best_idx_o = cur_idx;
            best_val_o = val_i;
        end
    end

    // Index tracker and candidate registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else if (valid_i) begin
            idx_q      <= cur_idx + 1'b1;
            best_idx_q <= best_idx_o;
            best_val_q <= best_val_o;
        end
    end

endmodule

// File: rtl/mnist_seq_ctrl.sv
// MNIST accelerator sequencer: clear, pixel walk, drain, argmax, done.
// Optional cycle counter enabled by defining MNIST_SEQ_PERF_EN.
module mnist_seq_ctrl
    import mnist_pkg::*;
#(
    parameter int NPIX    = NPIX_DEF,
    parameter int NCLS    = NCLS_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    localparam int AW     = $clog2(NPIX),
    localparam int CW     = $clog2(NCLS),
    localparam int DW     = $clog2(MAC_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    output logic [AW-1:0]         pix_addr,
    output logic                  mac_clr,
    output logic                  mac_en,
    input  logic [NCLS*ACC_W-1:0] results,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         class_out,
    output logic [ACC_W-1:0]      max_out,
    output logic [31:0]           perf_cycles
);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic [CW-1:0]    k_q, k_d;
    logic             mac_clr_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    class_q;
    logic [ACC_W-1:0] max_q;
    logic [ACC_W-1:0] cur_val;
    logic [CW-1:0]    best_idx;
    logic [ACC_W-1:0] best_val;

    // Next-state, address, drain and class-index decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drn_d   = drn_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                addr_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!hold) begin
                    if (addr_q == AW'(NPIX - 1)) begin
                        addr_d  = '0;
                        drn_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == DW'(MAC_LAT - 1)) begin
                    k_d     = '0;
                    state_d = S_ARGMAX;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            S_ARGMAX: begin
                if (k_q == CW'(NCLS - 1)) state_d = S_DONE;
                else k_d = k_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counters, plus registered strobes and result latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            drn_q     <= '0;
            k_q       <= '0;
            mac_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            class_q   <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            drn_q     <= drn_d;
            k_q       <= k_d;
            mac_clr_q <= (state_d == S_CLEAR);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                class_q <= best_idx;
                max_q   <= best_val;
            end
        end
    end

    assign cur_val = results[int'(k_q) * ACC_W +: ACC_W];

    mnist_argmax #(
        .NCLS  (NCLS),
        .ACC_W (ACC_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (reset),
        .start_i    ((state_q == S_ARGMAX) && (k_q == '0)),
        .valid_i    (state_q == S_ARGMAX),
        .val_i      (cur_val),
        .best_idx_o (best_idx),
        .best_val_o (best_val)
    );

`ifdef MNIST_SEQ_PERF_EN
    logic [31:0] cnt_q;
    logic [31:0] perf_q;

    // Cycle counter from CLEAR through DONE, latched on DONE entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            perf_q <= '0;
        end else begin
            if (state_q == S_IDLE && state_d == S_CLEAR)
                cnt_q <= 32'd1;
            else if (state_q != S_IDLE)
                cnt_q <= sat_inc(cnt_q);
            if (state_d == S_DONE)
                perf_q <= sat_inc(cnt_q);
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

    assign pix_addr  = addr_q;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = (state_q == S_RUN) && !hold;
    assign busy      = busy_q;
    assign done      = done_q;
    assign class_out = class_q;
    assign max_out   = max_q;

endmodule

// File: tb/tb_mnist_seq_ctrl.sv
// Directed bench for mnist_seq_ctrl with hand-computed expectations.
// Perf expectation follows MNIST_SEQ_PERF_EN.
module tb_mnist_seq_ctrl;

    localparam int NPIX  = 784;
    localparam int NCLS  = 10;
    localparam int ACC_W = 32;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic                  hold = 1'b0;
    logic [9:0]            pix_addr;
    logic                  mac_clr;
    logic                  mac_en;
    logic [NCLS*ACC_W-1:0] results;
    logic                  busy;
    logic                  done;
    logic [3:0]            class_out;
    logic [ACC_W-1:0]      max_out;
    logic [31:0]           perf_cycles;

    logic signed [31:0] res_v [NCLS];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        results = '0;
        for (int i = 0; i < NCLS; i++)
            results[i*ACC_W +: ACC_W] = res_v[i];
    end

    mnist_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hold        (hold),
        .pix_addr    (pix_addr),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .results     (results),
        .busy        (busy),
        .done        (done),
        .class_out   (class_out),
        .max_out     (max_out),
        .perf_cycles (perf_cycles)
    );

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pix_addr"}, pix_addr, 0);
        chk({tag, " mac_clr"}, mac_clr, 0);
        chk({tag, " mac_en"}, mac_en, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " class_out"}, class_out, 0);
        chk({tag, " max_out"}, max_out, 0);
        chk({tag, " perf"}, perf_cycles, 0);
    endtask

    function automatic longint perf_exp(input int cyc);
`ifdef MNIST_SEQ_PERF_EN
        return cyc;
`else
        return 0;
`endif
    endfunction

    task automatic run(input string tag, input bit do_hold,
                       input bit spur, input int exp_done,
                       input int exp_cls, input longint exp_max);
        int n, en_cnt, clr_cnt, done_at, hcnt, both;
        n = 0; en_cnt = 0; clr_cnt = 0;
        done_at = -1; hcnt = 0; both = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 1;
        while (n < 1200) begin
            @(negedge clk);
            start = spur && (n == 300 || n == exp_done);
            hold = do_hold && hcnt < 10 && pix_addr == 10'd50;
            #1;
            if (hold) begin
                hcnt++;
                chk({tag, " hold addr"}, pix_addr, 50);
                chk({tag, " hold mac_en"}, mac_en, 0);
            end
            if (mac_en) en_cnt++;
            if (mac_clr) clr_cnt++;
            if (mac_en && mac_clr) both++;
            if (n == 1) chk({tag, " busy rise"}, busy, 1);
            if (done) begin
                done_at = n;
                break;
            end
            @(posedge clk);
            n++;
        end
        hold = 1'b0;
        chk({tag, " done cycle"}, done_at, exp_done);
        chk({tag, " mac_en count"}, en_cnt, NPIX);
        chk({tag, " mac_clr count"}, clr_cnt, 1);
        chk({tag, " clr&en"}, both, 0);
        chk({tag, " class"}, class_out, exp_cls);
        chk({tag, " max"}, $signed(max_out), exp_max);
        chk({tag, " perf"}, perf_cycles, perf_exp(exp_done));
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy fall"}, busy, 0);
        chk({tag, " done pulse"}, done, 0);
        clr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mac_clr || busy) clr_cnt++;
        end
        chk({tag, " no restart"}, clr_cnt, 0);
        chk({tag, " class hold"}, class_out, exp_cls);
    endtask

    initial begin
        for (int i = 0; i < NCLS; i++) res_v[i] = 0;
        #12;
        chk_reset("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NCLS; i++) res_v[i] = i * 100 - 300;
        res_v[7] = 1234;
        run("nominal", 0, 0, 798, 7, 1234);

        for (int i = 0; i < NCLS; i++) res_v[i] = -5;
        run("all_neg5", 0, 0, 798, 0, -5);

        for (int i = 0; i < NCLS; i++) res_v[i] = -2;
        res_v[2] = 3;
        res_v[8] = 3;
        run("tie3", 0, 0, 798, 2, 3);

        for (int i = 0; i < NCLS; i++) res_v[i] = -100 - i;
        res_v[9] = -1;
        run("neg_max9", 0, 0, 798, 9, -1);

        for (int i = 0; i < NCLS; i++) res_v[i] = i * 10;
        run("hold10", 1, 0, 808, 9, 90);

        for (int i = 0; i < NCLS; i++) res_v[i] = 50 - i;
        run("spur_start", 0, 1, 798, 0, 50);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300 && pix_addr != 10'd100; i++)
            @(negedge clk);
        chk("abort addr", pix_addr, 100);
        #2 reset = 1'b0;
        #1;
        chk_reset("abort");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NCLS; i++) res_v[i] = -7;
        res_v[4] = 77;
        run("after_abort", 0, 0, 798, 4, 77);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
